seg_display_ctrl: RTL and testbench

// Display stage downstream of the async FIFO read side. Accepts 16-bit words (data_2 / data_2_valid),

---
 rtl/seg_display_ctrl.sv | 176 +++++++++++++++++
 tb/tb_seg_display_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seg_display_ctrl.sv
// 16-bit word -> 5-digit BCD (sequential double dabble) -> 8-digit multiplexed common-anode 7-seg.
// Accept-to-display latency 17 cycles; words arriving while busy go to a 1-deep pending slot, newest wins.
module seg_display_ctrl #(
    parameter int unsigned REFRESH_DIV   = 100000,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data,
    input  logic        data_valid,
    input  logic [1:0]  modulo,
    input  logic [2:0]  prog,
    output logic        busy,
    output logic [7:0]  an,
    output logic [7:0]  dec_ddp
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int unsigned      CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    state_t            state_q, state_d;
    logic [15:0]       bin_q, bin_d;
    logic [19:0]       bcd_q, bcd_d;
    logic [3:0]        iter_q, iter_d;
    logic [19:0]       disp_q, disp_d;
    logic [15:0]       pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;
    logic [CNT_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        an_q, an_d;
    logic [7:0]        seg_q, seg_d;

    logic [19:0]       bcd_adj;
    logic [35:0]       shifted;

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        logic [7:0] c;
        case (d)
            4'd0:    c = 8'h03;
            4'd1:    c = 8'h9F;
            4'd2:    c = 8'h25;
            4'd3:    c = 8'h0D;
            4'd4:    c = 8'h99;
            4'd5:    c = 8'h49;
            4'd6:    c = 8'h41;
            4'd7:    c = 8'h1F;
            4'd8:    c = 8'h01;
            4'd9:    c = 8'h09;
            default: c = 8'hFF;
        endcase
        return c;
    endfunction

    // Add-3 correction on every nibble that would overflow past 9 after the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int n = 0; n < 5; n++) begin
            if (bcd_q[4*n +: 4] >= 4'd5) begin
                bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        iter_d     = iter_q;
        disp_d     = disp_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        shifted    = {bcd_adj[18:0], bin_q, 1'b0};

        case (state_q)
            S_IDLE: begin
                if (data_valid || pend_vld_q) begin
                    state_d    = S_SHIFT;
                    bin_d      = data_valid ? data : pend_q;
                    bcd_d      = '0;
                    iter_d     = '0;
                    pend_vld_d = 1'b0;
                end
            end
            S_SHIFT: begin
                bcd_d  = shifted[35:16];
                bin_d  = shifted[15:0];
                iter_d = iter_q + 4'd1;
                if (iter_q == 4'd15) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                disp_d  = bcd_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if ((state_q != S_IDLE) && data_valid) begin
            pend_d     = data;
            pend_vld_d = 1'b1;
        end
    end

    always_comb begin
        scan_cnt_d = scan_cnt_q + CNT_W'(1);
        idx_d      = idx_q;
        if (scan_cnt_q == CNT_LAST) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 3'd1;
        end
    end

    // A digit above units is blank only when it and every more-significant digit are zero.
    always_comb begin
        an_d  = ~(8'd1 << idx_q);
        seg_d = 8'hFF;
        case (idx_q)
            3'd0: seg_d = seg_code(disp_q[3:0]);
            3'd1: seg_d = (BLANK_LEADING && (disp_q[19:4]  == '0)) ? 8'hFF : seg_code(disp_q[7:4]);
            3'd2: seg_d = (BLANK_LEADING && (disp_q[19:8]  == '0)) ? 8'hFF : seg_code(disp_q[11:8]);
            3'd3: seg_d = (BLANK_LEADING && (disp_q[19:12] == '0)) ? 8'hFF : seg_code(disp_q[15:12]);
            3'd4: seg_d = (BLANK_LEADING && (disp_q[19:16] == '0)) ? 8'hFF : seg_code(disp_q[19:16]);
            3'd5: seg_d = 8'hFF;
            3'd6: seg_d = seg_code({1'b0, prog}) & 8'hFE;
            3'd7: begin
                case (modulo)
                    2'b10:   seg_d = 8'h71;
                    2'b01:   seg_d = 8'hE1;
                    2'b00:   seg_d = 8'hFD;
                    default: seg_d = 8'h61;
                endcase
            end
            default: seg_d = 8'hFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            iter_q     <= '0;
            disp_q     <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            scan_cnt_q <= '0;
            idx_q      <= '0;
            an_q       <= 8'hFF;
            seg_q      <= 8'hFF;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            iter_q     <= iter_d;
            disp_q     <= disp_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign an      = an_q;
    assign dec_ddp = seg_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl with a 4-cycle refresh; two instances cover both blanking modes.
module tb_seg_display_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data = '0;
    logic        data_valid = 1'b0;
    logic [1:0]  modulo = 2'b00;
    logic [2:0]  prog = 3'd0;
    logic        busy, busy_nb;
    logic [7:0]  an, an_nb;
    logic [7:0]  dec_ddp, dec_nb;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seg_display_ctrl #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut (
        .clk(clk), .rst(rst), .data(data), .data_valid(data_valid),
        .modulo(modulo), .prog(prog), .busy(busy), .an(an), .dec_ddp(dec_ddp)
    );

    seg_display_ctrl #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .data(data), .data_valid(data_valid),
        .modulo(modulo), .prog(prog), .busy(busy_nb), .an(an_nb), .dec_ddp(dec_nb)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [15:0] word);
        data       = word;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
    endtask

    task automatic chk_digit(input string tag, input bit nb, input int d, input logic [7:0] exp);
        logic [7:0] tgt;
        bit         hit;
        tgt = ~(8'd1 << d);
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            tick();
            if ((nb ? an_nb : an) === tgt) hit = 1'b1;
        end
        if (!hit) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: digit %0d never selected, an observed %02h expected %02h",
                   tag, d, (nb ? an_nb : an), tgt);
        end else begin
            chk(tag, nb ? dec_nb : dec_ddp, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (busy === 1'b0) done = 1'b1;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: busy observed %b expected 0 within 40 cycles", tag, busy);
        end
    endtask

    logic [7:0] idle_codes [8] = '{8'h03, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'hFD};

    initial begin
        // Reset state
        #3 rst = 1'b0;
        tick();
        tick();
        chk("rst_an",      an,               8'hFF);
        chk("rst_dec",     dec_ddp,          8'hFF);
        chk("rst_busy",    {7'd0, busy},     8'h00);
        chk("rst_busy_nb", {7'd0, busy_nb},  8'h00);
        rst = 1'b1;

        // Idle scan: each digit held 4 cycles, wraps after digit 7
        for (int n = 1; n <= 36; n++) begin
            tick();
            chk("scan_an",  an,      ~(8'd1 << (((n - 1) / 4) % 8)));
            chk("scan_dec", dec_ddp, idle_codes[((n - 1) / 4) % 8]);
        end
        chk_digit("idle_nb_d1", 1'b1, 1, 8'h03);

        // 65535: busy for exactly 17 cycles, then digits 5,3,5,5,6
        pulse(16'd65535);
        for (int i = 0; i < 17; i++) begin
            chk("t2_busy_hi", {7'd0, busy}, 8'h01);
            tick();
        end
        chk("t2_busy_lo", {7'd0, busy}, 8'h00);
        chk_digit("t2_d0", 1'b0, 0, 8'h49);
        chk_digit("t2_d1", 1'b0, 1, 8'h0D);
        chk_digit("t2_d2", 1'b0, 2, 8'h49);
        chk_digit("t2_d3", 1'b0, 3, 8'h49);
        chk_digit("t2_d4", 1'b0, 4, 8'h41);

        // 100 with and without leading-zero blanking
        pulse(16'd100);
        wait_idle("t3_idle");
        chk_digit("t3_d0", 1'b0, 0, 8'h03);
        chk_digit("t3_d1", 1'b0, 1, 8'h03);
        chk_digit("t3_d2", 1'b0, 2, 8'h9F);
        chk_digit("t3_d3", 1'b0, 3, 8'hFF);
        chk_digit("t3_d4", 1'b0, 4, 8'hFF);
        chk_digit("t3_nb_d2", 1'b1, 2, 8'h9F);
        chk_digit("t3_nb_d3", 1'b1, 3, 8'h03);
        chk_digit("t3_nb_d4", 1'b1, 4, 8'h03);

        // 100 accepted, 200 and 300 arrive while busy: only 300 follows
        pulse(16'd100);
        tick();
        tick();
        pulse(16'd200);
        tick();
        pulse(16'd300);
        for (int i = 0; i < 12; i++) tick();
        chk("t4_gap_idle", {7'd0, busy}, 8'h00);
        tick();
        chk("t4_pend_acc", {7'd0, busy}, 8'h01);
        for (int i = 0; i < 17; i++) tick();
        chk("t4_done", {7'd0, busy}, 8'h00);
        for (int i = 0; i < 3; i++) tick();
        chk("t4_no_third", {7'd0, busy}, 8'h00);
        chk_digit("t4_d0", 1'b0, 0, 8'h03);
        chk_digit("t4_d1", 1'b0, 1, 8'h03);
        chk_digit("t4_d2", 1'b0, 2, 8'h0D);
        chk_digit("t4_d3", 1'b0, 3, 8'hFF);

        // Source letter and prog digit
        modulo = 2'b10;
        prog   = 3'd3;
        chk_digit("t5_fib", 1'b0, 7, 8'h71);
        chk_digit("t5_prog", 1'b0, 6, 8'h0C);
        chk_digit("t5_blank5", 1'b0, 5, 8'hFF);
        modulo = 2'b01;
        chk_digit("t5_timer", 1'b0, 7, 8'hE1);
        modulo = 2'b11;
        chk_digit("t5_inval", 1'b0, 7, 8'h61);
        modulo = 2'b00;
        prog   = 3'd7;
        chk_digit("t5_idle", 1'b0, 7, 8'hFD);
        chk_digit("t5_prog7", 1'b0, 6, 8'h1E);

        // Reset mid-conversion clears display and aborts the word
        pulse(16'd12345);
        wait_idle("t6_idle");
        chk_digit("t6_pre_d0", 1'b0, 0, 8'h49);
        chk_digit("t6_pre_d1", 1'b0, 1, 8'h99);
        chk_digit("t6_pre_d4", 1'b0, 4, 8'h9F);
        pulse(16'd9);
        for (int i = 0; i < 8; i++) tick();
        chk("t6_mid_busy", {7'd0, busy}, 8'h01);
        rst = 1'b0;
        #1;
        chk("t6_an",   an,           8'hFF);
        chk("t6_dec",  dec_ddp,      8'hFF);
        chk("t6_busy", {7'd0, busy}, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk_digit("t6_post_d0", 1'b0, 0, 8'h03);
        chk_digit("t6_post_d1", 1'b0, 1, 8'hFF);
        chk("t6_post_busy", {7'd0, busy}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
